// File: rtl/cache_pkg.sv
// Shared types for the cache trace-command path: opcode encoding, the
// 36-bit command word and the frontend FSM states.
package cache_pkg;

  localparam int CMD_W = 36;

  typedef enum logic [3:0] {
    OP_READ     = 4'd0,
    OP_WRITE    = 4'd1,
    OP_IFETCH   = 4'd2,
    OP_INVAL    = 4'd3,
    OP_SNOOP_RD = 4'd4,
    OP_CLEAR    = 4'd8,
    OP_PRINT    = 4'd9
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_DUMP_WAIT = 2'd2
  } state_t;

  // Ops 0..4 are forwarded to the cache core; the rest are handled locally.
  function automatic logic is_mem_op(input logic [3:0] op);
    return op <= 4'd4;
  endfunction

endpackage

// File: rtl/cache_cmd_fifo.sv
// Synchronous command FIFO with extra-bit wrap pointers; full/empty are
// derived from registered pointers only, so neither depends on push/pop.
module cache_cmd_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  cmd_t i_din,
  input  logic i_pop,
  output cmd_t o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  // Head is read combinationally so the FSM can decode and pop in one cycle.
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/cache_cmd_frontend.sv
// Trace command frontend: buffers commands, decodes opcodes, drives the cache
// core req/ack handshake. Statistics counters exist only with CMD_STATS_EN.
module cache_cmd_frontend
  import cache_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             core_req,
  output op_t              core_op,
  output logic [31:0]      core_addr,
  input  logic             core_ack,
  input  logic             core_hit,
  output logic             clear_req,
  output logic             dump_req,
  input  logic             dump_done,
  output logic             illegal_op,
  output logic             busy,
  output logic [CNT_W-1:0] stat_reads,
  output logic [CNT_W-1:0] stat_writes,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_misses
);

  state_t      r_state, w_state_next;
  op_t         r_op;
  logic [31:0] r_addr;
  logic        r_clear_req, r_dump_req, r_illegal;
  cmd_t        w_head;
  logic        w_full, w_empty;
  logic        w_pop, w_load, w_clear, w_dump, w_illegal, w_done;

  cache_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (cmd_valid),
    .i_din   (cmd_t'(cmd_data)),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_dump       = 1'b0;
    w_illegal    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (is_mem_op(w_head.op)) begin
            w_load       = 1'b1;
            w_state_next = ST_ISSUE;
          end else if (w_head.op == OP_CLEAR) begin
            w_clear = 1'b1;
          end else if (w_head.op == OP_PRINT) begin
            w_dump       = 1'b1;
            w_state_next = ST_DUMP_WAIT;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (core_ack) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_DUMP_WAIT: begin
        if (dump_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_READ;
      r_addr      <= '0;
      r_clear_req <= 1'b0;
      r_dump_req  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clear_req <= w_clear;
      r_dump_req  <= w_dump;
      r_illegal   <= w_illegal;
      if (w_load) begin
        r_op   <= w_head.op;
        r_addr <= w_head.addr;
      end
    end
  end

  assign cmd_ready  = !w_full;
  assign core_req   = (r_state == ST_ISSUE);
  assign core_op    = r_op;
  assign core_addr  = r_addr;
  assign clear_req  = r_clear_req;
  assign dump_req   = r_dump_req;
  assign illegal_op = r_illegal;
  assign busy       = (r_state != ST_IDLE) || !w_empty;

`ifdef CMD_STATS_EN
  logic [3:0]            w_inc;
  logic [3:0][CNT_W-1:0] w_cnt;
  logic                  w_rd, w_wr;

  assign w_rd  = (r_op == OP_READ) || (r_op == OP_IFETCH);
  assign w_wr  = (r_op == OP_WRITE);
  // Index order: reads, writes, hits, misses. Snoop/inval ops touch none.
  assign w_inc = {w_done && (w_rd || w_wr) && !core_hit,
                  w_done && (w_rd || w_wr) &&  core_hit,
                  w_done && w_wr,
                  w_done && w_rd};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_clear) begin
        r_cnt <= '0;
      end else if (w_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
    assign w_cnt[gi] = r_cnt;
  end

  assign stat_reads  = w_cnt[0];
  assign stat_writes = w_cnt[1];
  assign stat_hits   = w_cnt[2];
  assign stat_misses = w_cnt[3];
`else
  logic w_unused_stats;
  assign w_unused_stats = w_done ^ core_hit;
  assign stat_reads     = '0;
  assign stat_writes    = '0;
  assign stat_hits      = '0;
  assign stat_misses    = '0;
`endif

endmodule

// File: tb/tb_cache_cmd_frontend.sv
// Bench for cache_cmd_frontend: queue-based command model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_cache_cmd_frontend;
  import cache_pkg::*;

  localparam int DEPTH    = 4;
  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef CMD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [35:0]         cmd_data = '0;
  logic                core_req;
  op_t                 core_op;
  logic [31:0]         core_addr;
  logic                core_ack = 1'b0;
  logic                core_hit = 1'b0;
  logic                clear_req, dump_req, illegal_op, busy;
  logic                dump_done = 1'b0;
  logic [TB_CNT_W-1:0] stat_reads, stat_writes, stat_hits, stat_misses;

  always #5 clk = ~clk;

  cache_cmd_frontend #(.FIFO_DEPTH(DEPTH), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .core_req(core_req), .core_op(core_op), .core_addr(core_addr),
    .core_ack(core_ack), .core_hit(core_hit),
    .clear_req(clear_req), .dump_req(dump_req), .dump_done(dump_done),
    .illegal_op(illegal_op), .busy(busy),
    .stat_reads(stat_reads), .stat_writes(stat_writes),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Responder knobs, written by the main sequence only.
  bit ack_en = 1'b1;
  int ack_delay = 3;
  bit hit_val = 1'b0;
  bit stray_ack = 1'b0;

  // Inputs as seen by the DUT at each rising edge.
  bit          s_valid, s_ack, s_hit, s_done;
  logic [35:0] s_data;

  // Behavioural model: queued commands, what is in flight, statistics.
  cmd_t m_q[$];
  cmd_t m_cur;
  bit   m_issue, m_dump, m_expect, prev_req;
  int   m_reads, m_writes, m_hits, m_misses;
  int   n_rise = 0, n_ill = 0, n_clr = 0, n_dmp = 0, cur_len = 0, last_len = 0;

  initial forever begin
    @(posedge clk);
    s_valid = cmd_valid;
    s_data  = cmd_data;
    s_ack   = core_ack;
    s_hit   = core_hit;
    s_done  = dump_done;
  end

  // Core responder: acks after ack_delay cycles of core_req.
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(negedge clk);
      core_hit = hit_val;
      if (reset) begin
        rc = 0;
        core_ack = 1'b0;
      end else if (core_req) begin
        rc++;
        core_ack = ack_en && (rc >= ack_delay);
      end else begin
        rc = 0;
        core_ack = stray_ack;
      end
    end
  end

  // Compare process: applies the last edge to the model, then checks outputs.
  initial begin
    cmd_t h;
    bit   acc, ev_req;
    int   nev;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_q.delete();
        m_issue = 0; m_dump = 0; m_expect = 0; prev_req = 0; cur_len = 0;
        m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0;
        check("rst_core_req", 64'(core_req), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pulses", 64'({clear_req, dump_req, illegal_op}), 64'(0));
        check("rst_stats", 64'({stat_reads, stat_writes, stat_hits, stat_misses}), 64'(0));
      end else begin
        if (m_issue && s_ack) begin
          if (m_cur.op == OP_READ || m_cur.op == OP_IFETCH) m_reads = sat_inc(m_reads);
          if (m_cur.op == OP_WRITE) m_writes = sat_inc(m_writes);
          if (m_cur.op inside {OP_READ, OP_WRITE, OP_IFETCH}) begin
            if (s_hit) m_hits = sat_inc(m_hits);
            else       m_misses = sat_inc(m_misses);
          end
          m_issue = 0;
        end
        if (m_dump && s_done) m_dump = 0;
        acc    = s_valid && (m_q.size() < DEPTH);
        ev_req = core_req && !prev_req;
        nev    = int'(ev_req) + int'(clear_req) + int'(dump_req) + int'(illegal_op);
        n_rise += int'(ev_req);
        n_ill  += int'(illegal_op);
        n_clr  += int'(clear_req);
        n_dmp  += int'(dump_req);
        if (m_expect) begin
          h = m_q.pop_front();
          check("dispatch_events", 64'(nev), 64'(1));
          if (int'(h.op) <= 4) begin
            check("dispatch_req", 64'(ev_req), 64'(1));
            m_issue = 1;
            m_cur = h;
          end else if (h.op == OP_CLEAR) begin
            check("dispatch_clear", 64'(clear_req), 64'(1));
            m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0;
          end else if (h.op == OP_PRINT) begin
            check("dispatch_dump", 64'(dump_req), 64'(1));
            m_dump = 1;
          end else begin
            check("dispatch_illegal", 64'(illegal_op), 64'(1));
          end
        end else begin
          check("spurious_event", 64'(nev), 64'(0));
        end
        if (acc) m_q.push_back(cmd_t'(s_data));
        check("core_req", 64'(core_req), 64'(m_issue));
        if (m_issue) begin
          check("core_op", 64'(core_op), 64'(m_cur.op));
          check("core_addr", 64'(core_addr), 64'(m_cur.addr));
        end
        check("cmd_ready", 64'(cmd_ready), 64'(m_q.size() < DEPTH));
        check("busy", 64'(busy), 64'(m_issue || m_dump || (m_q.size() > 0)));
        check("stat_reads", 64'(stat_reads), 64'(STATS ? m_reads : 0));
        check("stat_writes", 64'(stat_writes), 64'(STATS ? m_writes : 0));
        check("stat_hits", 64'(stat_hits), 64'(STATS ? m_hits : 0));
        check("stat_misses", 64'(stat_misses), 64'(STATS ? m_misses : 0));
        m_expect = !m_issue && !m_dump && (m_q.size() > 0);
        if (core_req) cur_len++;
        else if (prev_req) begin
          last_len = cur_len;
          cur_len = 0;
        end
        prev_req = core_req;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] addr);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = {op, addr};
    while (!ok && n < 200) begin
      ok = cmd_ready;
      step();
      n++;
    end
    cmd_valid = 1'b0;
    check("push_accept", 64'(ok), 64'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    check("wait_idle", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; ack_en = 1'b1; ack_delay = 3; hit_val = 1'b0;
    stray_ack = 1'b0; dump_done = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int base;
    step();
    check("lit_rst_ready", 64'(cmd_ready), 64'(1));
    check("lit_rst_req", 64'(core_req), 64'(0));
    step();
    reset = 1'b0;
    step();

    // Single read, miss, ack on third cycle of core_req.
    base = n_rise;
    push(4'd0, 32'h0000_1000);
    wait_idle();
    check("a_req_len", 64'(last_len), 64'(3));
    check("a_req_count", 64'(n_rise - base), 64'(1));
    check("a_reads", 64'(stat_reads), 64'(STATS ? 1 : 0));
    check("a_misses", 64'(stat_misses), 64'(STATS ? 1 : 0));

    // Write then ifetch on the same address, both hits.
    do_reset();
    hit_val = 1'b1;
    push(4'd1, 32'h0000_2000);
    push(4'd2, 32'h0000_2000);
    wait_idle();
    check("b_writes", 64'(stat_writes), 64'(STATS ? 1 : 0));
    check("b_reads", 64'(stat_reads), 64'(STATS ? 1 : 0));
    check("b_hits", 64'(stat_hits), 64'(STATS ? 2 : 0));

    // Back-pressure: one in ISSUE plus four queued fills the FIFO.
    do_reset();
    hit_val = 1'b1;
    ack_en = 1'b0;
    push(4'd0, 32'h100);
    push(4'd1, 32'h104);
    push(4'd2, 32'h108);
    push(4'd3, 32'h10C);
    push(4'd4, 32'h110);
    check("c_full", 64'(cmd_ready), 64'(0));
    check("c_req_held", 64'(core_req), 64'(1));
    cmd_valid = 1'b1;
    cmd_data  = {4'd0, 32'h114};
    ack_en = 1'b1;
    step();
    check("c_full_ack", 64'(cmd_ready), 64'(0));
    step();
    check("c_full_idle", 64'(cmd_ready), 64'(0));
    check("c_req_drop", 64'(core_req), 64'(0));
    step();
    check("c_ready_after_pop", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 1'b0;
    wait_idle();
    check("c_reads", 64'(stat_reads), 64'(STATS ? 3 : 0));
    check("c_writes", 64'(stat_writes), 64'(STATS ? 1 : 0));
    check("c_hits", 64'(stat_hits), 64'(STATS ? 4 : 0));

    // Illegal opcode, then print waiting on dump_done.
    do_reset();
    base = n_rise;
    push(4'd7, 32'h77);
    push(4'd9, 32'h99);
    repeat (5) step();
    check("d_illegal", 64'(n_ill), 64'(1));
    check("d_dump", 64'(n_dmp), 64'(1));
    check("d_no_req", 64'(n_rise - base), 64'(0));
    check("d_busy", 64'(busy), 64'(1));
    dump_done = 1'b1;
    step();
    dump_done = 1'b0;
    check("d_idle", 64'(busy), 64'(0));

    // Stray ack in IDLE, then clear.
    do_reset();
    push(4'd0, 32'h200);
    push(4'd2, 32'h204);
    push(4'd1, 32'h208);
    wait_idle();
    base = n_rise;
    stray_ack = 1'b1;
    repeat (3) step();
    stray_ack = 1'b0;
    step();
    check("e_stray_req", 64'(n_rise - base), 64'(0));
    check("e_reads", 64'(stat_reads), 64'(STATS ? 2 : 0));
    check("e_misses", 64'(stat_misses), 64'(STATS ? 3 : 0));
    base = n_clr;
    push(4'd8, 32'h0);
    step();
    check("e_clear_pulse", 64'(clear_req), 64'(1));
    check("e_clear_reads", 64'(stat_reads), 64'(0));
    check("e_clear_misses", 64'(stat_misses), 64'(0));
    step();
    check("e_clear_once", 64'(clear_req), 64'(0));
    check("e_clear_count", 64'(n_clr - base), 64'(1));

    // Saturation: seventeen read hits.
    do_reset();
    hit_val = 1'b1;
    ack_delay = 1;
    for (int i = 0; i < 17; i++) push(4'd0, 32'(i * 4));
    wait_idle();
    check("f_reads_sat", 64'(stat_reads), 64'(STATS ? CNT_MAX : 0));
    check("f_hits_sat", 64'(stat_hits), 64'(STATS ? CNT_MAX : 0));

    // Reset mid-transaction with two commands queued.
    do_reset();
    ack_en = 1'b0;
    push(4'd0, 32'h300);
    push(4'd0, 32'h304);
    push(4'd0, 32'h308);
    check("g_req_before", 64'(core_req), 64'(1));
    check("g_busy_before", 64'(busy), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("g_rst_req", 64'(core_req), 64'(0));
    check("g_rst_ready", 64'(cmd_ready), 64'(1));
    check("g_rst_busy", 64'(busy), 64'(0));
    step();
    reset = 1'b0;
    ack_en = 1'b1;
    base = n_rise;
    repeat (10) step();
    check("g_no_req_after", 64'(n_rise - base), 64'(0));
    check("g_idle_after", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
